// File: rtl/static_reg_group_if.sv
// Static register bus between the group mux (master) and one register group (slave).
interface static_reg_group_if;
    logic        scan_id;
    logic        static_wen;
    logic        static_ren;
    logic [19:0] static_addr;
    logic [31:0] static_wdata;
    logic [31:0] static_rdata;
    logic        static_ready;

    modport master (
        output scan_id, static_wen, static_ren, static_addr, static_wdata,
        input  static_rdata, static_ready
    );

    modport slave (
        input  scan_id, static_wen, static_ren, static_addr, static_wdata,
        output static_rdata, static_ready
    );
endinterface

// File: rtl/static_reg_group.sv
// One register group on the static bus: R/W config bank plus read-only status bank,
// fixed-latency access answered with a registered one-cycle ready pulse.
module static_reg_group #(
    parameter logic [1:0]  GROUP_ID      = 2'b00,
    parameter int          NUM_REGS      = 16,
    parameter int          ACCESS_LAT    = 2,
    parameter logic [31:0] RESET_VAL     = 32'h0000_0000,
    parameter logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst,
    static_reg_group_if.slave        bus,
    output logic [NUM_REGS*32-1:0]   cfg_out,
    input  logic [NUM_REGS*32-1:0]   status_in
);
    localparam int          IDX_W      = $clog2(NUM_REGS);
    localparam logic [3:0]  LAT_LOAD   = (ACCESS_LAT > 0) ? 4'(ACCESS_LAT - 1) : 4'd0;
    localparam logic [15:0] NUM_REGS_W = 16'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   bank_r;
    logic                   wr_r;
    logic [15:0]            idx_r;
    logic [31:0]            wdata_r;
    logic [3:0]             cnt_r;
    logic [NUM_REGS*32-1:0] cfg_r;
    logic                   ready_r;
    logic [31:0]            rdata_r;

    logic                   req_s;
    logic                   accept_s;
    logic                   in_range_s;
    logic                   cfg_we_s;
    logic                   ready_nxt_s;
    logic [31:0]            rdata_nxt_s;
    logic [IDX_W-1:0]       idx_sel_s;

    assign req_s      = bus.static_wen | bus.static_ren;
    assign idx_sel_s  = idx_r[IDX_W-1:0];
    // Range check uses the full word index so aliasing high indices are rejected.
    assign in_range_s = (idx_r < NUM_REGS_W);

    // Next-state decode plus the response data/write strobe produced in RESP.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        ready_nxt_s = 1'b0;
        rdata_nxt_s = 32'h0000_0000;
        cfg_we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && (bus.static_addr[19:18] == GROUP_ID)) begin
                    accept_s = 1'b1;
                    if (ACCESS_LAT > 0) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = RESP;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                ready_nxt_s = 1'b1;
                state_nxt_s = DONE;
                if (wr_r) begin
                    cfg_we_s = ~bank_r & in_range_s;
                end else if (!in_range_s) begin
                    rdata_nxt_s = BAD_ADDR_DATA;
                end else if (bank_r) begin
                    rdata_nxt_s = status_in[{idx_sel_s, 5'b00000} +: 32];
                end else begin
                    rdata_nxt_s = cfg_r[{idx_sel_s, 5'b00000} +: 32];
                end
            end
            DONE: begin
                // Hold here until the master drops its request so it runs only once.
                if (!req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture on accept and wait-cycle countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_r  <= 1'b0;
            wr_r    <= 1'b0;
            idx_r   <= 16'h0000;
            wdata_r <= 32'h0000_0000;
            cnt_r   <= 4'd0;
        end else if (accept_s) begin
            bank_r  <= bus.scan_id;
            wr_r    <= bus.static_wen;
            idx_r   <= bus.static_addr[17:2];
            wdata_r <= bus.static_wdata;
            cnt_r   <= LAT_LOAD;
        end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Config register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_r <= {NUM_REGS{RESET_VAL}};
        end else if (cfg_we_s) begin
            cfg_r[{idx_sel_s, 5'b00000} +: 32] <= wdata_r;
        end
    end

    // Registered response: rdata is zero whenever ready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ready_r <= ready_nxt_s;
            rdata_r <= rdata_nxt_s;
        end
    end

    assign bus.static_ready = ready_r;
    assign bus.static_rdata = rdata_r;
    assign cfg_out          = cfg_r;
endmodule

// File: doc/static_reg_group.md
Name: static_reg_group

Overview:
- Responder end of the static register bus: one register group that sits behind the group mux on one of its A/B/C legs.
- Decodes a static access, runs a fixed-latency access, returns static_rdata with a one-cycle static_ready pulse.
- Holds NUM_REGS 32-bit config registers (read/write, driven to the group's logic).
- Exposes NUM_REGS 32-bit status words (read-only, sampled from the group's logic).

Parameters:
- GROUP_ID, 2'b00: value of static_addr[19:18] this instance answers to.
- NUM_REGS, 16: number of config registers and of status words (power of 2, 2..256).
- ACCESS_LAT, 2: wait cycles between accept and response (0..15).
- RESET_VAL, 32'h0000_0000: reset value of every config register.
- BAD_ADDR_DATA, 32'hDEAD_BEEF: read data returned for an out-of-range index.

Ports:
- clk, input, 1: single clock, all logic on its rising edge.
- rst, input, 1: synchronous reset, active-high.
- scan_id, input, 1: bank select; 0 = config bank (R/W), 1 = status bank (read-only).
- static_wen, input, 1: write request, held until static_ready.
- static_ren, input, 1: read request, held until static_ready.
- static_addr, input, 20: [19:18] group, [17:2] word index, [1:0] ignored.
- static_wdata, input, 32: write data.
- static_rdata, output, 32: read data, valid only while static_ready=1, otherwise 0.
- static_ready, output, 1: one-cycle completion pulse.
- cfg_out, output, NUM_REGS*32: config registers; register i occupies [32*i+31:32*i].
- status_in, input, NUM_REGS*32: status words, same packing as cfg_out.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset state: state=IDLE, static_ready=0, static_rdata=0, every cfg register=RESET_VAL, internal latches=0.
- Reset mid-operation: the access is abandoned, no write commits, no ready pulse; a still-held request is then re-accepted as new.
- States: IDLE, WAIT, RESP, DONE.
- IDLE: accept when (static_wen|static_ren) && static_addr[19:18]==GROUP_ID.
  - On accept, latch scan_id, op (write if static_wen=1, else read), static_addr[17:2], static_wdata.
  - Next state is WAIT if ACCESS_LAT>0, otherwise RESP.
  - Requests for other GROUP_IDs are ignored; the mux already zeroes unselected legs.
- WAIT: a 4-bit counter loads ACCESS_LAT-1 on accept and decrements each cycle. Go to RESP when the counter is 0. Input changes during WAIT are ignored (latched values are used).
- Latency: accept sampled at edge T; static_ready=1 in the cycle after edge T+1+ACCESS_LAT, for exactly 1 cycle.
- RESP: static_ready=1 for this cycle only.
  - Write with bank 0 and index<NUM_REGS: the config register updates at the edge ending RESP (visible on cfg_out the next cycle).
  - Write with bank 1 or index>=NUM_REGS: dropped silently, still acknowledged; static_rdata=0.
  - Read, bank 0: static_rdata = config register[index].
  - Read, bank 1: static_rdata = status_in word[index], sampled combinationally in RESP.
  - Read, index>=NUM_REGS (index uses the full [17:2] field): static_rdata = BAD_ADDR_DATA.
- Simultaneous static_wen and static_ren: treated as a write; static_rdata=0.
- DONE: wait until static_wen=0 and static_ren=0, then go to IDLE. This prevents a held request from executing twice. A new access needs at least one idle cycle between requests.
- static_rdata is registered and is 0 in every cycle where static_ready=0.

Test Plan:
- Write then read, latency: GROUP_ID=01, ACCESS_LAT=2. Write addr 20'h4_0008, wdata 32'h1234_5678, held until ready. Required: ready 3 cycles after accept; cfg_out[95:64]=32'h1234_5678 the next cycle. A read of the same address returns 32'h1234_5678 with ready, and rdata=0 before and after the pulse.
- Status bank: scan_id=1, status_in word 5 = 32'hCAFE_0005, read addr 20'h4_0014. Required: rdata=32'hCAFE_0005. A write of 32'hFFFF_FFFF to the same address with scan_id=1 is acked and cfg register 5 is unchanged.
- Out of range: NUM_REGS=16, read addr 20'h4_0040 (index 16). Required: ready pulse, rdata=32'hDEAD_BEEF. A write to that address is acked and no cfg bit changes.
- Hold and other group: request held 10 cycles past ready produces exactly one ready pulse; a request with addr[19:18]=10 produces no ready pulse and no cfg change.
- Edge cases: wen=ren=1 with wdata 32'hA5A5_A5A5 to index 0 writes the register and returns rdata=0. ACCESS_LAT=0 gives ready in the cycle after accept.
- Reset mid-access: assert rst during WAIT of a write to index 3 with 32'h0000_00FF. Required: no ready pulse and cfg register 3 = RESET_VAL. After rst deasserts with the request still held, the write completes normally once.
